tv_sequencer: RTL

//  Synthesizable test-vector sequencer. It sits directly upstream of a small combinational DUT,

---
 rtl/tv_seq_if.sv | 30 +++
 rtl/tv_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/tv_seq_if.sv
// Host/vector-ROM/DUT-facing bus of the test-vector sequencer.
// The slave modport is the sequencer side; master is the surrounding harness.
interface tv_seq_if #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int ADDR_W = 3
) ();
  logic                    start;
  logic [ADDR_W:0]         num_vecs;
  logic [ADDR_W-1:0]       vec_addr;
  logic [N_IN+N_OUT-1:0]   vec_data;
  logic [N_IN-1:0]         dut_in;
  logic [N_OUT-1:0]        dut_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [ADDR_W:0]         err_count;
  logic                    err_valid;
  logic [ADDR_W-1:0]       err_index;

  modport master (
    output start, num_vecs, vec_data, dut_out,
    input  vec_addr, dut_in, busy, done, pass, err_count, err_valid, err_index
  );

  modport slave (
    input  start, num_vecs, vec_data, dut_out,
    output vec_addr, dut_in, busy, done, pass, err_count, err_valid, err_index
  );
endinterface

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: fetches {inputs, expected} from a sync ROM, drives a
// combinational DUT, waits SETTLE cycles, compares and logs mismatches.
module tv_sequencer #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int ADDR_W = 3,
  parameter int SETTLE = 1
) (
  input  logic    clk,
  input  logic    reset,
  tv_seq_if.slave bus
);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_WAIT, S_CHECK, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   vec_addr_q, vec_addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic [N_OUT-1:0]    exp_q, exp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     err_count_q, err_count_d;
  logic [ADDR_W-1:0]   err_index_q, err_index_d;
  logic                err_valid_q, err_valid_d;
  logic [ADDR_W:0]     n_clamp;

  assign n_clamp = (bus.num_vecs > DEPTH) ? DEPTH : bus.num_vecs;

  always_comb begin
    state_d     = state_q;
    vec_addr_d  = vec_addr_q;
    last_d      = last_q;
    dut_in_d    = dut_in_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    err_index_d = err_index_q;
    err_valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          err_count_d = '0;
          err_index_d = '0;
          vec_addr_d  = '0;
          if (n_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            // last index kept as ADDR_W bits so a full-depth run never wraps
            last_d  = ADDR_W'(n_clamp - 1'b1);
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_APPLY;
      S_APPLY: begin
        dut_in_d = bus.vec_data[N_OUT +: N_IN];
        exp_d    = bus.vec_data[N_OUT-1:0];
        cnt_d    = CNT_W'(SETTLE - 1);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (bus.dut_out != exp_q) begin
          err_count_d = err_count_q + (ADDR_W+1)'(1);
          err_index_d = vec_addr_q;
          err_valid_d = 1'b1;
        end
        if (vec_addr_q == last_q) begin
          state_d = S_DONE;
        end else begin
          vec_addr_d = vec_addr_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vec_addr_q  <= '0;
      last_q      <= '0;
      dut_in_q    <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
      err_index_q <= '0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_addr_q  <= vec_addr_d;
      last_q      <= last_d;
      dut_in_q    <= dut_in_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      err_index_q <= err_index_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign bus.vec_addr  = vec_addr_q;
  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_APPLY) ||
                         (state_q == S_WAIT)  || (state_q == S_CHECK);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass      = (state_q == S_DONE) && (err_count_q == '0);
  assign bus.err_count = err_count_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_index = err_index_q;
endmodule
